// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, ALUOp encodings and the control bundle
// carried down the pipeline.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose destination
// is a source operand actually read by the instruction in ID.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_alusrc,
  input  logic       id_memwrite,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  logic rs1_used;
  logic rs2_used;

  // rs2 is read by R-type, store (data) and branch (compare)
  assign rs1_used = id_valid;
  assign rs2_used = id_valid & (~id_alusrc | id_memwrite);

  assign hazard = ex_valid & ex_memread & (ex_rd != 5'd0) &
                  (((ex_rd == id_rs1) & rs1_used) | ((ex_rd == id_rs2) & rs2_used));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-driven flush and
// saturating stall/flush event counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             id_alusrc,
  input  logic             id_memwrite,
  input  logic             id_memread,
  input  logic             id_branch,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_alusrc,
  output logic             ex_memwrite,
  output logic             ex_memread,
  output logic             ex_branch,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;

  assign id_ctrl = '{alusrc:   id_alusrc,
                     memwrite: id_memwrite,
                     memread:  id_memread,
                     branch:   id_branch,
                     memtoreg: id_memtoreg,
                     regwrite: id_regwrite,
                     aluop:    id_aluop};

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_alusrc   (id_alusrc),
    .id_memwrite (id_memwrite),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // A flush discards the ID instruction anyway, so no stall is needed
  assign stall = hazard & ~ex_flush & ~reset;

  // Bubbles clear only valid and control; data fields hold since EX ignores them
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_funct7b5 <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_ctrl;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
    end
  end

  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule
